// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - port indices and FSM encoding shared by the data-memory arbiter
package dmem_arb_pkg;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_rr_grant.sv
// rtl/dmem_rr_grant.sv - two-way round-robin priority select, one-hot grant
module dmem_rr_grant (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter, core port 0 / dma port 1
// Optional grant locking is built in when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [1:0]          rq_we,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_wdata,
  input  logic [1:0]          rq_lock,
  output logic [1:0]          rs_valid,
  output logic [DATA_W-1:0]   rs_rdata,
  output logic                rs_err,
  output logic                mem_memrw,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_rr_ptr;
  logic              w_leave_lock;
  logic [1:0]        w_valid_eff, w_grant;
  logic              w_accept, w_gidx, w_we, w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        r_rs_valid;
  logic [DATA_W-1:0] r_rs_rdata;
  logic              r_rs_err;

  dmem_rr_grant u_rr_grant (
    .i_valid (w_valid_eff),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign w_accept   = |w_grant;
  assign w_gidx     = w_grant[1];
  assign w_we       = rq_we[w_gidx];
  assign w_addr     = w_gidx ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
  assign w_wdata    = w_gidx ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
  assign w_in_range = ({1'b0, w_addr} < LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= PORT_CORE;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_leave_lock = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    case (r_state)
      IDLE: begin
        if (w_accept && rq_lock[w_gidx]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_gidx;
        end
      end
      LOCKED: begin
        // owner releases by an unlocked accept or by dropping lock while not requesting
        if (!rq_lock[r_owner] && (w_accept || !rq_valid[r_owner])) begin
          w_state_nxt  = IDLE;
          w_leave_lock = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`else
    w_state_nxt = IDLE;
`endif
  end

  always_comb begin
    w_valid_eff = rq_valid;
    if (r_state == LOCKED) w_valid_eff = rq_valid & (r_owner ? 2'b10 : 2'b01);
  end

`ifndef DMEM_ARB_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = ^rq_lock;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= PORT_CORE;
    end else if (r_state == IDLE && w_accept) begin
      r_rr_ptr <= ~w_gidx;
    end else if (w_leave_lock) begin
      r_rr_ptr <= ~r_owner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_valid <= 2'b00;
      r_rs_rdata <= '0;
      r_rs_err   <= 1'b0;
    end else begin
      r_rs_valid <= w_grant;
      r_rs_err   <= w_accept & ~w_in_range;
      r_rs_rdata <= (w_accept && !w_we && w_in_range) ? mem_rdata : '0;
    end
  end

  assign rq_ready    = w_grant;
  assign mem_address = w_addr;
  assign mem_wdata   = w_wdata;
  assign mem_memrw   = ~rst & w_accept & w_we & w_in_range;
  assign rs_valid    = r_rs_valid;
  assign rs_rdata    = r_rs_rdata;
  assign rs_err      = r_rs_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a request-level model
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rq_valid, rq_ready, rq_we, rq_lock, rs_valid;
  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [DW-1:0] rs_rdata, mem_wdata, mem_rdata;
  logic          rs_err, mem_memrw;
  logic [AW-1:0] mem_address;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
    .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_lock(rq_lock),
    .rs_valid(rs_valid), .rs_rdata(rs_rdata), .rs_err(rs_err),
    .mem_memrw(mem_memrw), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory the arbiter drives; out-of-range addresses alias so leaks show up
  logic [DW-1:0] env_mem [MW];
  logic [DW-1:0] pre_mem [MW];
  logic [DW-1:0] ref_mem [MW];
  logic          do_preload;

  assign mem_rdata = env_mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < MW; i++) env_mem[i] <= pre_mem[i];
    end else if (mem_memrw) begin
      env_mem[mem_address[9:2]] <= mem_wdata;
    end
  end

  int n_checks, n_errors;

  logic          m_ptr, m_locked, m_owner;
  logic [1:0]    exp_valid;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  logic [1:0]    o_rsv, o_ready, e_rsv, e_ready;
  logic [DW-1:0] o_rd, e_rd, o_wdata, e_wdata;
  logic          o_err, e_err, o_memrw, e_memrw;
  logic [AW-1:0] o_addr, e_addr;

  // one bus cycle: sample last cycle's response, drive a request set, predict grant and response
  task automatic do_cycle(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1);
    logic p;
    logic [31:0] a;
    logic inr;
    @(negedge clk);
    o_rsv = rs_valid; o_rd = rs_rdata; o_err = rs_err;
    e_rsv = exp_valid; e_rd = exp_rdata; e_err = exp_err;
    rq_valid = v; rq_we = we; rq_lock = lk;
    rq_addr = {a1, a0}; rq_wdata = {d1, d0};
    #1;
    o_ready = rq_ready; o_memrw = mem_memrw; o_addr = mem_address; o_wdata = mem_wdata;
    if (m_locked) e_ready = v[m_owner] ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    else if (v == 2'b11) e_ready = m_ptr ? 2'b10 : 2'b01;
    else e_ready = v;
    p = e_ready[1];
    a = p ? a1 : a0;
    inr = (a < 32'(MW * 4));
    e_addr = a;
    e_wdata = p ? d1 : d0;
    e_memrw = (e_ready != 2'b00) && we[p] && inr;
    exp_valid = e_ready; exp_rdata = '0; exp_err = 1'b0;
    if (e_ready != 2'b00) begin
      exp_err = !inr;
      if (we[p]) begin
        if (inr) ref_mem[a[9:2]] = e_wdata;
      end else if (inr) begin
        exp_rdata = ref_mem[a[9:2]];
      end
      if (!m_locked) m_ptr = !p;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (!m_locked) begin
      if (e_ready != 2'b00 && lk[p]) begin
        m_locked = 1'b1;
        m_owner = p;
      end
    end else if (!lk[m_owner] && (e_ready != 2'b00 || !v[m_owner])) begin
      m_locked = 1'b0;
      m_ptr = !m_owner;
    end
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle(2'b11, 2'b00, 2'b00, 32'h20, 32'h0, 32'h24, 32'h0);
      n_checks++; if (o_ready !== e_ready) begin n_errors++; $display("FAIL rst_pre_ready: got %b want %b", o_ready, e_ready); end
    end
    @(negedge clk);
    rst = 1'b1; rq_we = 2'b11;
    #1;
    n_checks += 3;
    if (rs_valid !== 2'b00) begin n_errors++; $display("FAIL rst_rs_valid: got %b want 00", rs_valid); end
    if (rs_rdata !== '0) begin n_errors++; $display("FAIL rst_rs_rdata: got %h want 0", rs_rdata); end
    if (mem_memrw !== 1'b0) begin n_errors++; $display("FAIL rst_memrw: got %b want 0", mem_memrw); end
    m_ptr = 1'b0; m_locked = 1'b0; m_owner = 1'b0;
    exp_valid = 2'b00; exp_rdata = '0; exp_err = 1'b0;
    @(negedge clk); #1;
    n_checks += 2;
    if (mem_memrw !== 1'b0) begin n_errors++; $display("FAIL rst_memrw_hold: got %b want 0", mem_memrw); end
    if (rs_valid !== 2'b00) begin n_errors++; $display("FAIL rst_rs_valid_hold: got %b want 00", rs_valid); end
    @(negedge clk);
    rst = 1'b0; rq_valid = 2'b00; rq_we = 2'b00;
    do_cycle(2'b11, 2'b00, 2'b00, 32'h30, 32'h0, 32'h34, 32'h0);
    n_checks += 2;
    if (o_ready !== 2'b01) begin n_errors++; $display("FAIL rst_first_grant: got %b want 01", o_ready); end
    if (o_rsv !== 2'b00) begin n_errors++; $display("FAIL rst_no_rsp: got %b want 00", o_rsv); end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks += 2;
    if (o_rsv !== e_rsv) begin n_errors++; $display("FAIL rst_first_rsp: got %b want %b", o_rsv, e_rsv); end
    if (o_rd !== e_rd) begin n_errors++; $display("FAIL rst_first_rdata: got %h want %h", o_rd, e_rd); end
  endtask

  task automatic test_single_port();
    do_cycle(2'b01, 2'b01, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    n_checks += 4;
    if (o_ready !== 2'b01) begin n_errors++; $display("FAIL sp_wr_ready: got %b want 01", o_ready); end
    if (o_memrw !== 1'b1) begin n_errors++; $display("FAIL sp_wr_memrw: got %b want 1", o_memrw); end
    if (o_addr !== 32'h10) begin n_errors++; $display("FAIL sp_wr_addr: got %h want 10", o_addr); end
    if (o_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sp_wr_wdata: got %h want deadbeef", o_wdata); end
    do_cycle(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    n_checks += 4;
    if (o_rsv !== 2'b01) begin n_errors++; $display("FAIL sp_wr_rsp: got %b want 01", o_rsv); end
    if (o_err !== 1'b0) begin n_errors++; $display("FAIL sp_wr_err: got %b want 0", o_err); end
    if (o_rd !== 32'h0) begin n_errors++; $display("FAIL sp_wr_rdata: got %h want 0", o_rd); end
    if (o_memrw !== 1'b0) begin n_errors++; $display("FAIL sp_rd_memrw: got %b want 0", o_memrw); end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks += 3;
    if (o_rsv !== 2'b01) begin n_errors++; $display("FAIL sp_rd_rsp: got %b want 01", o_rsv); end
    if (o_rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sp_rd_rdata: got %h want deadbeef", o_rd); end
    if (o_err !== 1'b0) begin n_errors++; $display("FAIL sp_rd_err: got %b want 0", o_err); end
  endtask

  task automatic test_contention();
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [1:0]  pwe;
    logic [1:0]  prev_ready;
    for (int p = 0; p < 2; p++) begin
      pa[p] = 32'($urandom_range(0, MW-1)) << 2; pd[p] = $urandom; pwe[p] = 1'($urandom_range(0, 1));
    end
    prev_ready = 2'b00;
    for (int c = 0; c < 6; c++) begin
      do_cycle(2'b11, pwe, 2'b00, pa[0], pd[0], pa[1], pd[1]);
      n_checks += 4;
      if (o_ready !== e_ready) begin n_errors++; $display("FAIL cont_ready: cycle %0d got %b want %b", c, o_ready, e_ready); end
      if ($countones(o_ready) != 1) begin n_errors++; $display("FAIL cont_onehot: cycle %0d got %b want one bit", c, o_ready); end
      if (o_memrw !== e_memrw) begin n_errors++; $display("FAIL cont_memrw: cycle %0d got %b want %b", c, o_memrw, e_memrw); end
      if (o_rsv !== e_rsv) begin n_errors++; $display("FAIL cont_rsv: cycle %0d got %b want %b", c, o_rsv, e_rsv); end
      if (c > 0) begin
        n_checks++;
        if (o_ready === prev_ready) begin n_errors++; $display("FAIL cont_alternate: cycle %0d got %b twice want alternation", c, o_ready); end
      end
      if (e_rsv != 2'b00) begin
        n_checks++;
        if (o_rd !== e_rd) begin n_errors++; $display("FAIL cont_rdata: cycle %0d got %h want %h", c, o_rd, e_rd); end
      end
      prev_ready = o_ready;
      for (int p = 0; p < 2; p++) if (e_ready[p]) begin
        pa[p] = 32'($urandom_range(0, MW-1)) << 2; pd[p] = $urandom; pwe[p] = 1'($urandom_range(0, 1));
      end
    end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks += 2;
    if (o_rsv !== e_rsv) begin n_errors++; $display("FAIL cont_last_rsv: got %b want %b", o_rsv, e_rsv); end
    if (o_rd !== e_rd) begin n_errors++; $display("FAIL cont_last_rdata: got %h want %h", o_rd, e_rd); end
  endtask

  task automatic test_range();
    do_cycle(2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h400, 32'h12345678);
    n_checks += 2;
    if (o_ready !== 2'b10) begin n_errors++; $display("FAIL rng_wr_ready: got %b want 10", o_ready); end
    if (o_memrw !== 1'b0) begin n_errors++; $display("FAIL rng_wr_memrw: got %b want 0", o_memrw); end
    do_cycle(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h400, 32'h0);
    n_checks += 3;
    if (o_rsv !== 2'b10) begin n_errors++; $display("FAIL rng_wr_rsv: got %b want 10", o_rsv); end
    if (o_err !== 1'b1) begin n_errors++; $display("FAIL rng_wr_err: got %b want 1", o_err); end
    if (o_memrw !== 1'b0) begin n_errors++; $display("FAIL rng_rd_memrw: got %b want 0", o_memrw); end
    do_cycle(2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks += 3;
    if (o_rsv !== 2'b10) begin n_errors++; $display("FAIL rng_rd_rsv: got %b want 10", o_rsv); end
    if (o_rd !== 32'h0) begin n_errors++; $display("FAIL rng_rd_rdata: got %h want 0", o_rd); end
    if (o_err !== 1'b1) begin n_errors++; $display("FAIL rng_rd_err: got %b want 1", o_err); end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks += 3;
    if (o_rsv !== 2'b01) begin n_errors++; $display("FAIL rng_w0_rsv: got %b want 01", o_rsv); end
    if (o_rd !== e_rd) begin n_errors++; $display("FAIL rng_w0_rdata: got %h want %h", o_rd, e_rd); end
    if (o_err !== 1'b0) begin n_errors++; $display("FAIL rng_w0_err: got %b want 0", o_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) do_cycle(2'b01, 2'b00, 2'b00, 32'(i * 4), 32'h0, 32'h0, 32'h0);
      else do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      if (i < 3) begin
        n_checks++;
        if (o_ready !== 2'b01) begin n_errors++; $display("FAIL b2b_ready: idx %0d got %b want 01", i, o_ready); end
      end
      if (i > 0) begin
        n_checks += 2;
        if (o_rsv !== 2'b01) begin n_errors++; $display("FAIL b2b_rsv: idx %0d got %b want 01", i - 1, o_rsv); end
        if (o_rd !== e_rd) begin n_errors++; $display("FAIL b2b_rdata: idx %0d got %h want %h", i - 1, o_rd, e_rd); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [1:0]  pv, pwe;
    pv = 2'b00; pwe = 2'b00;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 60; c++) begin
      for (int p = 0; p < 2; p++) if (!pv[p]) begin
        pv[p]  = ($urandom_range(0, 9) < 6);
        pwe[p] = 1'($urandom_range(0, 1));
        pd[p]  = $urandom;
        if ($urandom_range(0, 9) == 0) pa[p] = 32'h400 + (32'($urandom_range(0, 255)) << 2);
        else pa[p] = (32'($urandom_range(0, MW-1)) << 2) | 32'($urandom_range(0, 3));
      end
      do_cycle(pv, pwe, 2'b00, pa[0], pd[0], pa[1], pd[1]);
      n_checks += 3;
      if (o_ready !== e_ready) begin n_errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, o_ready, e_ready); end
      if (o_memrw !== e_memrw) begin n_errors++; $display("FAIL rnd_memrw: cycle %0d got %b want %b", c, o_memrw, e_memrw); end
      if (o_rsv !== e_rsv) begin n_errors++; $display("FAIL rnd_rsv: cycle %0d got %b want %b", c, o_rsv, e_rsv); end
      if (e_ready != 2'b00) begin
        n_checks++;
        if (o_addr !== e_addr) begin n_errors++; $display("FAIL rnd_addr: cycle %0d got %h want %h", c, o_addr, e_addr); end
      end
      if (e_rsv != 2'b00) begin
        n_checks += 2;
        if (o_rd !== e_rd) begin n_errors++; $display("FAIL rnd_rdata: cycle %0d got %h want %h", c, o_rd, e_rd); end
        if (o_err !== e_err) begin n_errors++; $display("FAIL rnd_err: cycle %0d got %b want %b", c, o_err, e_err); end
      end
      pv = pv & ~e_ready;
    end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (o_rsv !== e_rsv) begin n_errors++; $display("FAIL rnd_last_rsv: got %b want %b", o_rsv, e_rsv); end
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] lk;
    bit got;
    for (int k = 0; k < 4; k++) begin
      lk = (k < 3) ? 2'b10 : 2'b00;
      got = 1'b0;
      for (int t = 0; t < 4 && !got; t++) begin
        do_cycle(2'b11, 2'b10, lk, 32'h0, 32'h0, 32'(k * 4 + 32'h80), $urandom);
        got = e_ready[1];
        n_checks++;
        if (o_ready !== e_ready) begin n_errors++; $display("FAIL lock_ready: write %0d got %b want %b", k, o_ready, e_ready); end
        if (k > 0) begin
          n_checks++;
          if (o_ready !== 2'b10) begin n_errors++; $display("FAIL lock_owner_only: write %0d got %b want 10", k, o_ready); end
        end
      end
      if (!got) begin n_checks++; n_errors++; $display("FAIL lock_timeout: write %0d got no grant want grant", k); end
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          do_cycle(2'b01, 2'b00, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);
          n_checks++;
          if (o_ready !== 2'b00) begin n_errors++; $display("FAIL lock_gap_ready: gap %0d got %b want 00", g, o_ready); end
        end
      end
    end
    do_cycle(2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (o_ready !== 2'b01) begin n_errors++; $display("FAIL lock_release_grant: got %b want 01", o_ready); end
    do_cycle(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; rq_valid = 2'b00; rq_we = 2'b00; rq_lock = 2'b00;
    rq_addr = '0; rq_wdata = '0;
    m_ptr = 1'b0; m_locked = 1'b0; m_owner = 1'b0;
    exp_valid = 2'b00; exp_rdata = '0; exp_err = 1'b0;
    for (int i = 0; i < MW; i++) begin
      pre_mem[i] = $urandom | 32'h1;
      ref_mem[i] = pre_mem[i];
    end
    do_preload = 1'b1;
    repeat (3) @(negedge clk);
    do_preload = 1'b0;
    rst = 1'b0;
    test_reset();
    test_single_port();
    test_contention();
    test_range();
    test_back_to_back();
    test_random();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
